// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, parity-type and line-level constants shared by the
//   UART transmit and receive paths, plus a small parity helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package uart_pkg;

  // Frame sequencer states. The encoding is fixed so the receive path and any
  // debug tap that decodes the state register agree on the values.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Parity selection as carried on par_typ.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = ~PAR_EVEN;

  // Line levels: the line rests at mark (1); the start bit is a space (0).
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Width of a bit index able to address every data bit; at least one bit so
  // a degenerate one-bit frame still has a legal counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Parity bit from the XOR-reduction of the data: even parity sends the
  // reduction as-is, odd parity sends it inverted.
  function automatic logic parity_bit(input logic xor_red, input logic typ);
    return (typ == PAR_ODD) ? ~xor_red : xor_red;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: TX handshake between the system controller (master) and the
//   UART transmitter (slave): byte, request strobe, parity controls, and the
//   serial line plus busy status coming back.
// Latency: n/a (wiring only). Backpressure: master must hold off while busy=1.
//
// Signals:
//   p_data     master->slave  byte to transmit
//   data_valid master->slave  request strobe, p_data valid this cycle
//   par_en     master->slave  append a parity bit
//   par_typ    master->slave  0 even, 1 odd parity
//   tx_out     slave->master  serial line, idles high
//   busy       slave->master  frame in progress, requests ignored
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data,
    output data_valid,
    output par_en,
    output par_typ,
    input  tx_out,
    input  busy
  );

  modport slave (
    input  p_data,
    input  data_valid,
    input  par_en,
    input  par_typ,
    output tx_out,
    output busy
  );

endinterface

// File: rtl/parity_calc.sv
// parity_calc: combinational parity over the latched TX data word.
// Latency: 0 cycles (pure logic). Backpressure: none.
//
// Ports: i_data (latched data word), i_par_typ (0 even / 1 odd),
//   o_par_bit (bit to place on the line in the parity slot).
// Only present when UART_TX_PARITY_EN is defined; without it the transmitter
// carries no parity logic at all, so the module is not declared either.
`ifdef UART_TX_PARITY_EN
module parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_par_bit
);

  logic w_xor_red;

  assign w_xor_red = ^i_data;
  assign o_par_bit = parity_bit(w_xor_red, i_par_typ);

endmodule
`endif

// File: rtl/uart_tx.sv
// uart_tx: serializes one data word into start / data (LSB first) / optional
//   parity / stop frame on tx_out; clocked by the baud clock (1 cycle = 1 bit).
// Latency: request sampled at edge N -> start bit and busy=1 from edge N+1.
// Backpressure: busy=1 for the whole frame; requests seen while not idle are dropped.
//
// Ports:
//   clk  baud clock, one cycle per bit
//   rst  synchronous active-high reset
//   bus  uart_tx_if.slave: p_data/data_valid/par_en/par_typ in, tx_out/busy out
//
// Build option: define UART_TX_PARITY_EN to compile in the parity stage.
// Without it par_en/par_typ are still on the interface but are ignored and
// every frame is 1+DATA_WIDTH+1 bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int               CNT_W    = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  uart_state_e           r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_tx;
  logic                  r_busy;

`ifdef UART_TX_PARITY_EN
  logic r_par_en;
  logic r_par_typ;
  logic w_par_bit;

  // Parity is taken from the latched copy, so changes on p_data/par_typ
  // during the frame cannot disturb the bit that goes out.
  parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .i_data    (r_data),
    .i_par_typ (r_par_typ),
    .o_par_bit (w_par_bit)
  );
`else
  // Parity controls are accepted on the interface but have no function here.
  logic w_unused_par;
  assign w_unused_par = bus.par_en ^ bus.par_typ;
`endif

  // Single sequencer. tx_out/busy are registered from the current state, so
  // each state's line level appears one cycle after the state is entered:
  // the START state (entered at the request edge) drives the start bit from
  // the following edge, and the IDLE state clears busy at its closing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      r_tx      <= LINE_IDLE;
      r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_en  <= 1'b0;
      r_par_typ <= PAR_EVEN;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_tx   <= LINE_IDLE;
          r_busy <= 1'b0;
          if (bus.data_valid) begin
            r_data    <= bus.p_data;
`ifdef UART_TX_PARITY_EN
            r_par_en  <= bus.par_en;
            r_par_typ <= bus.par_typ;
`endif
            r_state   <= START;
          end
        end

        START: begin
          r_tx    <= START_BIT;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
          r_state <= DATA;
        end

        DATA: begin
          r_tx   <= r_data[r_cnt];
          r_busy <= 1'b1;
          // The counter stops on the last index rather than wrapping; it is
          // cleared again by START before the next frame.
          if (r_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            r_state <= r_par_en ? PARITY : STOP;
`else
            r_state <= STOP;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          r_tx    <= w_par_bit;
          r_busy  <= 1'b1;
          r_state <= STOP;
        end
`endif

        STOP: begin
          r_tx    <= LINE_IDLE;
          r_busy  <= 1'b1;
          r_state <= IDLE;
        end

        // Unreachable encodings (and PARITY when it is not built) fall back
        // to a quiet line.
        default: begin
          r_tx    <= LINE_IDLE;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_out = r_tx;
  assign bus.busy   = r_busy;

endmodule
